// File: rtl/cpu_types_pkg.sv
// Shared types for the data cache: address split, frame layout, FSM states.
// DCACHE_HIT_COUNT_EN adds the CNT state that writes the hit count after a flush.
package cpu_types_pkg;

  localparam int DBLK_WORDS = 2;
  localparam int DWAYS      = 2;
  localparam int DIDX_W     = 3;
  // Wide enough for the tag of the smallest legal cache (one set).
  localparam int DTAG_W     = 29;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [31-3-DIDX_W:0] tag;
    logic [DIDX_W-1:0]    idx;
    logic                 blkoff;
    logic [1:0]           bytoff;
  } dcache_addr_t;

  typedef struct packed {
    logic                         valid;
    logic                         dirty;
    logic [DTAG_W-1:0]            tag;
    word_t [DBLK_WORDS-1:0]       data;
  } dcache_frame_t;

  typedef enum logic [3:0] {
    IDLE,
    WB0,
    WB1,
    LD0,
    LD1,
    FLUSH0,
    FLUSH1,
`ifdef DCACHE_HIT_COUNT_EN
    CNT,
`endif
    DONE
  } dcache_state_t;

endpackage

// File: rtl/dcache_frame_array.sv
// Two-way frame storage with per-set LRU bits: synchronous writes and a
// combinational lookup returning both frames of a set plus hit/way-select.
module dcache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int SETS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(SETS)-1:0] rd_idx,
  input  logic [DTAG_W-1:0]       rd_tag,
  output dcache_frame_t           rd_frame0,
  output dcache_frame_t           rd_frame1,
  output logic                    rd_lru,
  output logic                    hit,
  output logic                    hit_way,
  input  logic                    wr_en,
  input  logic                    wr_way,
  input  logic [$clog2(SETS)-1:0] wr_idx,
  input  dcache_frame_t           wr_frame,
  input  logic                    lru_we,
  input  logic [$clog2(SETS)-1:0] lru_idx,
  input  logic                    lru_val
);

  dcache_frame_t   frames_q [DWAYS][SETS];
  logic [SETS-1:0] lru_q;
  logic            hit0, hit1;

  // Reset only clears the control bits; tags and data are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      lru_q <= '0;
      for (int w = 0; w < DWAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          frames_q[w][s].valid <= 1'b0;
          frames_q[w][s].dirty <= 1'b0;
        end
      end
    end else begin
      if (wr_en) frames_q[wr_way][wr_idx] <= wr_frame;
      if (lru_we) lru_q[lru_idx] <= lru_val;
    end
  end

  assign rd_frame0 = frames_q[1'b0][rd_idx];
  assign rd_frame1 = frames_q[1'b1][rd_idx];
  assign rd_lru    = lru_q[rd_idx];
  assign hit0      = rd_frame0.valid && (rd_frame0.tag == rd_tag);
  assign hit1      = rd_frame1.valid && (rd_frame1.tag == rd_tag);
  assign hit       = hit0 | hit1;
  assign hit_way   = hit1 & ~hit0;

endmodule

// File: rtl/dcache_responder.sv
// 2-way write-back data cache between pipeline and memory controller, with halt flush.
// DCACHE_HIT_COUNT_EN: count IDLE hits and write the count to HIT_CNT_ADDR after the flush.
module dcache_responder
  import cpu_types_pkg::*;
#(
  parameter int          SETS         = 8,
  parameter logic [31:0] HIT_CNT_ADDR = 32'h0000_3100
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int IDX_W = $clog2(SETS);
`ifdef DCACHE_HIT_COUNT_EN
  localparam dcache_state_t FLUSH_END = CNT;
`else
  localparam dcache_state_t FLUSH_END = DONE;
`endif

  dcache_state_t     state_q, state_d;
  logic              victim_q, victim_d;
  logic [IDX_W:0]    fptr_q, fptr_d;
`ifdef DCACHE_HIT_COUNT_EN
  word_t             hit_cnt_q, hit_cnt_d;
`endif
  dcache_addr_t      req_a;
  logic [IDX_W-1:0]  req_idx, fidx, rd_idx, wr_idx, lru_idx;
  logic [DTAG_W-1:0] req_tag;
  logic              blkoff, fway, is_req, flushing;
  dcache_frame_t     f0, f1, vic_frame, hit_frame, fl_frame, lru_frame, wr_frame;
  logic              rd_lru, hit, hit_way, wr_en, wr_way, lru_we, lru_val;
  logic              unused_bits;

  function automatic logic [31:0] blk_addr(input logic [DTAG_W-1:0] tag,
                                           input logic [IDX_W-1:0] idx,
                                           input logic off);
    blk_addr = ({3'b000, tag} << (3 + IDX_W)) | (32'(idx) << 3) | (32'(off) << 2);
  endfunction

  assign req_a       = dmemaddr;
  assign blkoff      = req_a.blkoff;
  assign unused_bits = ^{req_a.bytoff, req_a.tag, req_a.idx};
  assign req_idx     = dmemaddr[3 +: IDX_W];
  assign req_tag     = DTAG_W'(dmemaddr >> (3 + IDX_W));
  assign fidx        = fptr_q[IDX_W:1];
  assign fway        = fptr_q[0];
  assign is_req      = dmemREN | dmemWEN;
  assign flushing    = (state_q == FLUSH0) || (state_q == FLUSH1);
  assign rd_idx      = flushing ? fidx : req_idx;
  assign vic_frame   = victim_q ? f1 : f0;
  assign hit_frame   = hit_way ? f1 : f0;
  assign fl_frame    = fway ? f1 : f0;
  assign lru_frame   = rd_lru ? f1 : f0;
  assign flushed     = (state_q == DONE);

  dcache_frame_array #(.SETS(SETS)) u_frames (
    .clk      (CLK),
    .rst      (RST),
    .rd_idx   (rd_idx),
    .rd_tag   (req_tag),
    .rd_frame0(f0),
    .rd_frame1(f1),
    .rd_lru   (rd_lru),
    .hit      (hit),
    .hit_way  (hit_way),
    .wr_en    (wr_en),
    .wr_way   (wr_way),
    .wr_idx   (wr_idx),
    .wr_frame (wr_frame),
    .lru_we   (lru_we),
    .lru_idx  (lru_idx),
    .lru_val  (lru_val)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      victim_q  <= 1'b0;
      fptr_q    <= '0;
`ifdef DCACHE_HIT_COUNT_EN
      hit_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      victim_q  <= victim_d;
      fptr_q    <= fptr_d;
`ifdef DCACHE_HIT_COUNT_EN
      hit_cnt_q <= hit_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    victim_d  = victim_q;
    fptr_d    = fptr_q;
`ifdef DCACHE_HIT_COUNT_EN
    hit_cnt_d = hit_cnt_q;
`endif
    dhit      = 1'b0;
    dmemload  = '0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    daddr     = '0;
    dstore    = '0;
    wr_en     = 1'b0;
    wr_way    = victim_q;
    wr_idx    = req_idx;
    wr_frame  = vic_frame;
    lru_we    = 1'b0;
    lru_idx   = req_idx;
    lru_val   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (halt) begin
          fptr_d  = '0;
          state_d = FLUSH0;
        end else if (is_req && hit) begin
          dhit    = 1'b1;
          lru_we  = 1'b1;
          lru_val = ~hit_way;
`ifdef DCACHE_HIT_COUNT_EN
          hit_cnt_d = hit_cnt_q + 32'd1;
`endif
          // A simultaneous read and write is serviced as the write.
          if (dmemWEN) begin
            wr_en                 = 1'b1;
            wr_way                = hit_way;
            wr_frame              = hit_frame;
            wr_frame.data[blkoff] = dmemstore;
            wr_frame.dirty        = 1'b1;
          end else begin
            dmemload = hit_frame.data[blkoff];
          end
        end else if (is_req) begin
          victim_d = rd_lru;
          state_d  = (lru_frame.valid && lru_frame.dirty) ? WB0 : LD0;
        end
      end
      WB0, WB1: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(vic_frame.tag, req_idx, state_q == WB1);
        dstore = vic_frame.data[state_q == WB1];
        if (!dwait) state_d = (state_q == WB1) ? LD0 : WB1;
      end
      LD0: begin
        dREN  = 1'b1;
        daddr = blk_addr(req_tag, req_idx, 1'b0);
        if (!dwait) begin
          wr_en            = 1'b1;
          wr_frame.data[0] = dload;
          wr_frame.valid   = 1'b0;
          wr_frame.dirty   = 1'b0;
          state_d          = LD1;
        end
      end
      LD1: begin
        dREN  = 1'b1;
        daddr = blk_addr(req_tag, req_idx, 1'b1);
        if (!dwait) begin
          wr_en            = 1'b1;
          wr_frame.data[1] = dload;
          wr_frame.tag     = req_tag;
          wr_frame.valid   = 1'b1;
          wr_frame.dirty   = 1'b0;
          state_d          = IDLE;
        end
      end
      FLUSH0, FLUSH1: begin
        if (fl_frame.valid && fl_frame.dirty) begin
          dWEN   = 1'b1;
          daddr  = blk_addr(fl_frame.tag, fidx, state_q == FLUSH1);
          dstore = fl_frame.data[state_q == FLUSH1];
        end
        // Clean frames and a completed second word both advance the pointer.
        if (!(fl_frame.valid && fl_frame.dirty) || (state_q == FLUSH1 && !dwait)) begin
          if (state_q == FLUSH1) begin
            wr_en          = 1'b1;
            wr_way         = fway;
            wr_idx         = fidx;
            wr_frame       = fl_frame;
            wr_frame.dirty = 1'b0;
          end
          if (fptr_q == '1) begin
            state_d = FLUSH_END;
          end else begin
            fptr_d  = fptr_q + 1'b1;
            state_d = FLUSH0;
          end
        end else if (!dwait) begin
          state_d = FLUSH1;
        end
      end
`ifdef DCACHE_HIT_COUNT_EN
      CNT: begin
        dWEN   = 1'b1;
        daddr  = HIT_CNT_ADDR;
        dstore = hit_cnt_q;
        if (!dwait) state_d = DONE;
      end
`endif
      DONE: begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a wait-state memory model and a transaction log.
module tb_dcache_responder;

  localparam int WAIT = 2;

  logic        CLK = 1'b0;
  logic        RST, halt, dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore, dmemload;
  logic        dhit, flushed, dREN, dWEN, dwait;
  logic [31:0] daddr, dstore, dload;

  logic [31:0] mem [0:4095];
  logic        mem_init, hold_wait;
  int          wcnt;
  logic [64:0] log_q [0:63];
  int          log_n;
  int          ntests = 0;
  int          nfail  = 0;

  dcache_responder #(.SETS(8), .HIT_CNT_ADDR(32'h0000_3100)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .halt     (halt),
    .dmemREN  (dmemREN),
    .dmemWEN  (dmemWEN),
    .dmemaddr (dmemaddr),
    .dmemstore(dmemstore),
    .dhit     (dhit),
    .dmemload (dmemload),
    .flushed  (flushed),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dload    (dload),
    .dwait    (dwait)
  );

  always #5 CLK = ~CLK;

  assign dwait = (dREN | dWEN) && (hold_wait || wcnt != WAIT);
  assign dload = mem[daddr[13:2]];

  function automatic logic [31:0] init_word(input int i);
    case (i)
      'h10:    return 32'h0000_AAAA;
      'h11:    return 32'h0000_BBBB;
      default: return 32'h5000_0000 | 32'(i);
    endcase
  endfunction

  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
      wcnt  <= 0;
      log_n <= 0;
    end else if (dREN | dWEN) begin
      if (!dwait) begin
        if (dWEN) mem[daddr[13:2]] <= dstore;
        if (log_n < 64) log_q[log_n] <= {dWEN, daddr, dWEN ? dstore : dload};
        log_n <= log_n + 1;
        wcnt  <= 0;
      end else if (wcnt != WAIT) begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_req(input logic ren, input logic wen, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] ld);
    dmemREN = ren; dmemWEN = wen; dmemaddr = a; dmemstore = d;
    lat = 0;
    #1;
    while (!dhit && lat < 100) begin
      step();
      lat++;
    end
    ld = dmemload;
    step();
    dmemREN = 1'b0; dmemWEN = 1'b0;
  endtask

  function automatic logic [64:0] tx(input logic we, input logic [31:0] a, input logic [31:0] d);
    return {we, a, d};
  endfunction

  initial begin
    int          lat, mark, n;
    logic [31:0] ld;
    RST = 1'b1; mem_init = 1'b1; halt = 1'b0; hold_wait = 1'b0;
    dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
    step(); step();
    mem_init = 1'b0; RST = 1'b0;
    check("rst_dhit", dhit, 0);
    check("rst_flushed", flushed, 0);
    check("rst_strobes", {dREN, dWEN}, 0);
    check("rst_daddr_dstore", {daddr, dstore}, 0);
    check("rst_dmemload", dmemload, 0);

    // Cold read miss, then a hit on the other word of the block
    mark = log_n;
    run_req(1'b1, 1'b0, 32'h40, 32'h0, lat, ld);
    check("cold_lat", lat, 7);
    check("cold_data", ld, 32'h0000_AAAA);
    check("cold_ntx", log_n - mark, 2);
    check("cold_tx0", log_q[mark], tx(1'b0, 32'h40, 32'h0000_AAAA));
    check("cold_tx1", log_q[mark+1], tx(1'b0, 32'h44, 32'h0000_BBBB));
    run_req(1'b1, 1'b0, 32'h44, 32'h0, lat, ld);
    check("hit44_lat", lat, 0);
    check("hit44_data", ld, 32'h0000_BBBB);

    // Write hit, then read back, no memory traffic
    mark = log_n;
    run_req(1'b0, 1'b1, 32'h40, 32'h1234, lat, ld);
    check("whit_lat", lat, 0);
    run_req(1'b1, 1'b0, 32'h40, 32'h0, lat, ld);
    check("rd_after_w", {lat[7:0], ld}, {8'd0, 32'h1234});
    check("whit_ntx", log_n - mark, 0);
    #1;
    check("idle_no_req", {dhit, dmemload}, 0);

    // Second block into set 0 (way 1), then a dirty eviction of way 0
    mark = log_n;
    run_req(1'b1, 1'b0, 32'h140, 32'h0, lat, ld);
    check("fill140_lat", lat, 7);
    check("fill140_data", ld, 32'h5000_0050);
    check("fill140_tx1", log_q[mark+1], tx(1'b0, 32'h144, 32'h5000_0051));
    mark = log_n;
    run_req(1'b1, 1'b0, 32'h240, 32'h0, lat, ld);
    check("evict_lat", lat, 13);
    check("evict_data", ld, 32'h5000_0090);
    check("evict_ntx", log_n - mark, 4);
    check("evict_tx0", log_q[mark],   tx(1'b1, 32'h40,  32'h0000_1234));
    check("evict_tx1", log_q[mark+1], tx(1'b1, 32'h44,  32'h0000_BBBB));
    check("evict_tx2", log_q[mark+2], tx(1'b0, 32'h240, 32'h5000_0090));
    check("evict_tx3", log_q[mark+3], tx(1'b0, 32'h244, 32'h5000_0091));
    run_req(1'b1, 1'b0, 32'h140, 32'h0, lat, ld);
    check("keep140", {lat[7:0], ld}, {8'd0, 32'h5000_0050});
    mark = log_n;
    run_req(1'b1, 1'b0, 32'h40, 32'h0, lat, ld);
    check("refill40", {lat[7:0], ld}, {8'd7, 32'h0000_1234});
    check("refill40_ntx", log_n - mark, 2);

    // Simultaneous read+write on a hit behaves as a write
    run_req(1'b1, 1'b1, 32'h44, 32'hCAFE, lat, ld);
    check("rw_lat", lat, 0);
    run_req(1'b1, 1'b0, 32'h44, 32'h0, lat, ld);
    check("rw_data", {lat[7:0], ld}, {8'd0, 32'h0000_CAFE});

    // Write-allocate into set 1
    run_req(1'b0, 1'b1, 32'h48, 32'h7777, lat, ld);
    check("walloc_lat", lat, 7);

    // Flush on halt: set 0 way 0 and set 1 way 0 are dirty; hits so far = 11
    mark = log_n;
    halt = 1'b1;
    n = 0;
    while (!flushed && n < 400) begin
      step();
      n++;
    end
    halt = 1'b0;
    check("flush_done", flushed, 1);
`ifdef DCACHE_HIT_COUNT_EN
    check("flush_ntx", log_n - mark, 5);
    check("flush_cnt", log_q[mark+4], tx(1'b1, 32'h3100, 32'd11));
`else
    check("flush_ntx", log_n - mark, 4);
`endif
    check("flush_tx0", log_q[mark],   tx(1'b1, 32'h40, 32'h0000_1234));
    check("flush_tx1", log_q[mark+1], tx(1'b1, 32'h44, 32'h0000_CAFE));
    check("flush_tx2", log_q[mark+2], tx(1'b1, 32'h48, 32'h0000_7777));
    check("flush_tx3", log_q[mark+3], tx(1'b1, 32'h4C, 32'h5000_0013));
    dmemREN = 1'b1; dmemaddr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      step();
      check("done_hold", {flushed, dhit, dREN, dWEN}, 4'b1000);
    end
    dmemREN = 1'b0;

    // Reset during LD1 with the memory stalled
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst2_flushed", flushed, 0);
    dmemREN = 1'b1; dmemaddr = 32'h80;
    n = 0;
    #1;
    while (!(dREN && daddr == 32'h84) && n < 50) begin
      step();
      n++;
    end
    check("reach_ld1", {dREN, daddr}, {1'b1, 32'h84});
    hold_wait = 1'b1;
    step(); step();
    check("ld1_stall_stable", {dREN, dWEN, daddr}, {2'b10, 32'h84});
    RST = 1'b1;
    step();
    check("rst_abort", {dREN, dWEN, daddr}, 0);
    RST = 1'b0; hold_wait = 1'b0;
    #1;
    check("rst_abort_miss", dhit, 0);
    run_req(1'b1, 1'b0, 32'h80, 32'h0, lat, ld);
    check("refetch80", {lat[7:0], ld}, {8'd7, 32'h5000_0020});

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-cache end of the datapath/cache interface: answers the pipeline's dmemREN/dmemWEN requests with dhit/dmemload.
- Initiator toward the memory controller; issues dREN/dWEN word transactions and honours dwait.
- 2-way set-associative, write-back, write-allocate, 2 words per block, LRU replacement.
- On halt, flushes all dirty blocks, optionally writes a hit count, then raises flushed.

Parameters:
- SETS, 8, number of sets; power of two; index width = log2(SETS).
- HIT_CNT_ADDR, 32'h00003100, memory address that receives the hit count after the flush.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- halt  in  1  pipeline halted; flush request
- dmemREN  in  1  datapath read request
- dmemWEN  in  1  datapath write request
- dmemaddr  in  32  word address; bits [1:0] ignored
- dmemstore  in  32  write data
- dhit  out  1  request satisfied this cycle
- dmemload  out  32  read data; valid when dhit is high on a read
- flushed  out  1  flush complete; sticky
- dREN  out  1  memory read
- dWEN  out  1  memory write
- daddr  out  32  memory address
- dstore  out  32  memory write data
- dload  in  32  memory read data
- dwait  in  1  memory busy; transaction completes on the first cycle dwait=0

Behaviour:
- Reset, synchronous, active-high, applied on the CLK edge:
  - every valid, dirty and LRU bit cleared; hit counter = 0; state = IDLE.
  - outputs dhit, flushed, dREN, dWEN = 0; daddr, dstore, dmemload = 0.
  - RST mid-miss or mid-flush aborts the transaction: memory strobes drop next cycle and all frames are invalidated.
- Address split: tag = [31:3+idx], index, blkoff = [2], byte = [1:0].
- States: IDLE, WB0, WB1, LD0, LD1, FLUSH0, FLUSH1, CNT, DONE.
- IDLE, hit (valid and tag match in either way), combinational, same cycle:
  - dhit=1.
  - Read: dmemload = the word.
  - Write: word <= dmemstore, dirty <= 1, on the CLK edge.
  - LRU bit of the set <= the other way; hit counter increments.
- IDLE, miss: victim = LRU way. Dirty victim goes to WB0, clean victim to LD0.
- WB0/WB1:
  - dWEN=1, daddr = {victim tag, index, blkoff=0/1, 2'b00}, dstore = victim word.
  - Advance on dwait=0. WB1 then goes to LD0.
- LD0/LD1:
  - dREN=1, daddr = {req tag, index, 0/1, 2'b00}; word <= dload on dwait=0.
  - After LD1: tag written, valid=1, dirty=0, back to IDLE. The request then hits the following cycle.
  - Miss cost: one cycle per completed memory transaction, plus one cycle to return to IDLE.
- dwait=1 holds the state and keeps all memory outputs stable.
- dmemREN and dmemWEN both high: treated as a write.
- No request in IDLE: dhit=0, no state change.
- halt is sampled only in IDLE, so an in-progress miss completes first. On halt, go to FLUSH0.
- FLUSH0/FLUSH1 walk a frame pointer over sets 0..SETS-1, way 0 then way 1:
  - Dirty frames write both words, one per state.
  - Clean or invalid frames are skipped at one cycle each.
  - Each written frame has its dirty bit cleared.
  - Wrap past the last frame goes to CNT.
- CNT: dWEN=1, daddr=HIT_CNT_ADDR, dstore = hit counter; go to DONE on dwait=0.
- DONE: flushed=1 and held until RST; requests are ignored (dhit=0).
- Hit counter: 32-bit, wraps modulo 2^32, counts IDLE hits only.
- A post-miss hit also counts.

Optional Feature:
- DCACHE_HIT_COUNT_EN.
- Defined: the counter exists and CNT performs the write at HIT_CNT_ADDR.
- Undefined: no counter and no CNT state; flush wrap goes directly to DONE.

Decomposition:
- cpu_types_pkg receives:
  - dcache_addr_t (packed tag/idx/blkoff/bytoff);
  - dcache_frame_t (valid, dirty, tag, word_t data[2]);
  - dcache_state_t enum;
  - constants DBLK_WORDS=2 and DWAYS=2.
- One sub-module, dcache_frame_array: storage plus LRU bits, synchronous write, combinational two-way lookup/hit/way-select.
- The FSM stays in dcache_responder.

Test Plan:
- Cold read: REN addr 0x40, dload 0xAAAA/0xBBBB, dwait=1 for 2 cycles per access → dREN to 0x40 then 0x44; next cycle dhit=1, dmemload=0xAAAA; subsequent REN 0x44 hits with 0xBBBB.
- Write hit then read: WEN 0x40 data 0x1234 after fill → dhit same cycle, no memory traffic; REN 0x40 → 0x1234.
- Dirty eviction: fill 0x40 (dirty) and 0x140 into set 0; access 0x240 → dWEN 0x40, then 0x44 with old words, then dREN 0x240 and 0x244; the LRU way is replaced.
- Halt flush: two dirty frames, halt=1 → exactly four dWEN writes in frame order, then 0x3100 ← hit count (with the macro defined); flushed=1 and held for 10 cycles.
- RST asserted during LD1 with dwait=1 → next cycle dREN=0, and a REN of the same address misses.
- Simultaneous REN+WEN on a hit → written data stored, counted as one hit.
